// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: debounced switches/buttons, button press latch, LED register
// and a time-multiplexed 8-digit seven-segment display.
module io_bridge #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [9:0]  addr_low,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PsW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PsW-1:0] PsMax = PsW'(SCAN_DIV - 1);

  localparam logic [9:0] AddrSw      = 10'h000;
  localparam logic [9:0] AddrBtn     = 10'h004;
  localparam logic [9:0] AddrBtnPr   = 10'h008;
  localparam logic [9:0] AddrLed     = 10'h010;
  localparam logic [9:0] AddrSegVal  = 10'h020;
  localparam logic [9:0] AddrSegMask = 10'h024;

  logic [15:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_cand_q, sw_cand_d, sw_db_q, sw_db_d;
  logic [DbW-1:0] sw_cnt_q, sw_cnt_d;
  logic [4:0]     btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_cand_q, btn_cand_d;
  logic [4:0]     btn_db_q, btn_db_d, btn_pr_q, btn_pr_d;
  logic [DbW-1:0] btn_cnt_q, btn_cnt_d;
  logic [15:0]    led_q, led_d;
  logic [31:0]    seg_val_q, seg_val_d;
  logic [7:0]     seg_mask_q, seg_mask_d;
  logic [PsW-1:0] ps_q, ps_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     seg_an_q, seg_an_d, seg_cat_q, seg_cat_d;
  logic           rd_clr, wrap;

  function automatic logic [7:0] hex7seg(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Input conditioning: one candidate/counter per group, stable for DEBOUNCE_CYCLES to accept.
  always_comb begin
    sw_s1_d   = sw;
    sw_s2_d   = sw_s1_q;
    sw_cand_d = sw_cand_q;
    sw_cnt_d  = sw_cnt_q;
    sw_db_d   = sw_db_q;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q == DbMax) begin
      sw_db_d = sw_cand_q;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end

    btn_s1_d   = btn;
    btn_s2_d   = btn_s1_q;
    btn_cand_d = btn_cand_q;
    btn_cnt_d  = btn_cnt_q;
    btn_db_d   = btn_db_q;
    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
      btn_cnt_d  = '0;
    end else if (btn_cnt_q == DbMax) begin
      btn_db_d = btn_cand_q;
    end else begin
      btn_cnt_d = btn_cnt_q + 1'b1;
    end

    // A rising edge arriving on the clearing edge still latches.
    rd_clr   = io_read && (addr_low == AddrBtnPr);
    btn_pr_d = (btn_pr_q & ~{5{rd_clr}}) | (btn_db_d & ~btn_db_q);
  end

  always_comb begin
    led_d      = led_q;
    seg_val_d  = seg_val_q;
    seg_mask_d = seg_mask_q;
    if (io_write) begin
      case (addr_low)
        AddrLed:     led_d      = wdata[15:0];
        AddrSegVal:  seg_val_d  = wdata;
        AddrSegMask: seg_mask_d = wdata[7:0];
        default: ;
      endcase
    end
  end

  // Digit outputs load only on a slot change, from the index being entered.
  always_comb begin
    wrap      = (ps_q == PsMax);
    ps_d      = wrap ? '0 : ps_q + 1'b1;
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
    seg_an_d  = seg_an_q;
    seg_cat_d = seg_cat_q;
    if (wrap) begin
      seg_an_d  = seg_mask_q[idx_d] ? ~(8'h01 << idx_d) : 8'hFF;
      seg_cat_d = hex7seg(seg_val_q[{idx_d, 2'b00} +: 4]);
    end
  end

  always_comb begin
    rdata = '0;
    if (io_read) begin
      case (addr_low)
        AddrSw:      rdata = {16'b0, sw_db_q};
        AddrBtn:     rdata = {27'b0, btn_db_q};
        AddrBtnPr:   rdata = {27'b0, btn_pr_q};
        AddrLed:     rdata = {16'b0, led_q};
        AddrSegVal:  rdata = seg_val_q;
        AddrSegMask: rdata = {24'b0, seg_mask_q};
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_cand_q  <= '0;
      sw_cnt_q   <= '0;
      sw_db_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_cand_q <= '0;
      btn_cnt_q  <= '0;
      btn_db_q   <= '0;
      btn_pr_q   <= '0;
      led_q      <= '0;
      seg_val_q  <= '0;
      seg_mask_q <= 8'hFF;
      ps_q       <= '0;
      idx_q      <= '0;
      seg_an_q   <= 8'hFE;
      seg_cat_q  <= 8'hC0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      sw_cand_q  <= sw_cand_d;
      sw_cnt_q   <= sw_cnt_d;
      sw_db_q    <= sw_db_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_cand_q <= btn_cand_d;
      btn_cnt_q  <= btn_cnt_d;
      btn_db_q   <= btn_db_d;
      btn_pr_q   <= btn_pr_d;
      led_q      <= led_d;
      seg_val_q  <= seg_val_d;
      seg_mask_q <= seg_mask_d;
      ps_q       <= ps_d;
      idx_q      <= idx_d;
      seg_an_q   <= seg_an_d;
      seg_cat_q  <= seg_cat_d;
    end
  end

  assign led     = led_q;
  assign seg_an  = seg_an_q;
  assign seg_cat = seg_cat_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: stimulus queues expected values, a monitor compares them
// against the outputs on each sampled cycle.
module tb_io_bridge;

  localparam int KRd  = 0;
  localparam int KLed = 1;
  localparam int KAn  = 2;
  localparam int KCat = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [9:0]  addr_low = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [15:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  logic        peek = 1'b0;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  event        mon_ev;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  io_bridge #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_DIV       (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_read (io_read),
    .io_write(io_write),
    .addr_low(addr_low),
    .wdata   (wdata),
    .rdata   (rdata),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Monitor: pops every queued expectation whenever the bench strobes a sample.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or mon_ev);
      if (io_read || peek) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: rdata=%h led=%h with no expected value queued",
                   rdata, led);
        end
        while (sb.size() > 0) begin
          e = sb.pop_front();
          case (e.kind)
            KLed:    act = {16'b0, led};
            KAn:     act = {24'b0, seg_an};
            KCat:    act = {24'b0, seg_cat};
            default: act = rdata;
          endcase
          checks++;
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    io_read  = 1'b0;
    io_write = 1'b0;
    peek     = 1'b0;
  endtask

  task automatic want(input int kind, input logic [31:0] v, input string n);
    sb.push_back('{kind: kind, exp: v, name: n});
    peek = 1'b1;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] v, input string n);
    io_read  = 1'b1;
    addr_low = a;
    want(KRd, v, n);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    io_write = 1'b1;
    addr_low = a;
    wdata    = d;
  endtask

  initial begin
    int         idx;
    logic [7:0] an_e;

    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    want(KLed, 32'h0, "rst_led");
    want(KAn, 32'hFE, "rst_seg_an");
    want(KCat, 32'hC0, "rst_seg_cat");
    want(KRd, 32'h0, "rst_rdata");
    -> mon_ev;
    #1;
    peek   = 1'b0;
    clk_en = 1'b1;
    step();

    // LED write/readback, and read-during-write returns the old value.
    wr(10'h010, 32'hDEAD_BEEF);
    step();
    want(KLed, 32'hBEEF, "led_wr");
    rd(10'h010, 32'h0000_BEEF, "led_rd");
    step();
    wr(10'h010, 32'h0000_1234);
    rd(10'h010, 32'h0000_BEEF, "led_rw_pre");
    step();
    want(KLed, 32'h1234, "led_rw_post");
    step();

    // Short switch pulse must be rejected.
    sw = 16'h00A5;
    repeat (3) step();
    sw = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      rd(10'h000, 32'h0, "sw_glitch");
      step();
    end
    repeat (4) step();

    // Held switch value: accepted on edge 7.
    sw = 16'h00A5;
    for (int k = 0; k < 9; k++) begin
      rd(10'h000, (k >= 7) ? 32'h00A5 : 32'h0, "sw_debounce");
      step();
    end

    // Button press/release then clear-on-read.
    btn = 5'b00100;
    repeat (8) step();
    rd(10'h004, 32'h4, "btn_db_hi");
    btn = 5'b00000;
    step();
    repeat (8) step();
    rd(10'h004, 32'h0, "btn_db_lo");
    step();
    rd(10'h008, 32'h4, "btn_pressed");
    step();
    rd(10'h008, 32'h0, "btn_pressed_clr");
    step();

    // Press lands on the same edge as the clearing read.
    btn = 5'b00100;
    repeat (6) step();
    rd(10'h008, 32'h0, "btn_coinc_pre");
    step();
    rd(10'h008, 32'h4, "btn_coinc");
    step();
    rd(10'h008, 32'h0, "btn_coinc_clr");
    step();

    // Reset mid-run, observed while held.
    rst = 1'b1;
    want(KLed, 32'h0, "mid_rst_led");
    want(KAn, 32'hFE, "mid_rst_seg_an");
    want(KCat, 32'hC0, "mid_rst_seg_cat");
    rd(10'h000, 32'h0, "mid_rst_sw");
    @(negedge clk);
    #1;
    rst     = 1'b0;
    io_read = 1'b0;
    peek    = 1'b0;

    // Display scan; edge count restarts at reset release.
    wr(10'h020, 32'h7654_3210);
    step();
    wr(10'h024, 32'h0000_000F);
    step();
    for (int k = 2; k < 34; k++) begin
      idx  = (k / 4) % 8;
      an_e = (idx < 4) ? ~(8'h01 << idx) : 8'hFF;
      want(KAn, {24'b0, an_e}, "scan_seg_an");
      want(KCat, {24'b0, hex_tab[idx]}, "scan_seg_cat");
      step();
    end

    // Unmapped and idle accesses.
    wr(10'h010, 32'h0000_5A5A);
    step();
    wr(10'h100, 32'hFFFF_FFFF);
    step();
    want(KLed, 32'h5A5A, "unm_led_out");
    rd(10'h010, 32'h0000_5A5A, "unm_led_rd");
    step();
    rd(10'h020, 32'h7654_3210, "unm_seg_val");
    step();
    rd(10'h024, 32'h0000_000F, "unm_seg_mask");
    step();
    rd(10'h100, 32'h0, "unm_rd_100");
    step();
    rd(10'h00C, 32'h0, "unm_rd_00c");
    step();
    addr_low = 10'h010;
    want(KRd, 32'h0, "idle_rdata");
    step();
    rd(10'h000, 32'h00A5, "sw_after_rst");
    step();
    rd(10'h008, 32'h4, "btn_pr_after_rst");
    step();
    step();

    if (sb.size() != 0) begin
      checks++;
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
